// File: rtl/bitwise_logic_pipe.sv
// bitwise_logic_pipe
//   Registered bitwise logic unit. Each accepted beat applies one of eight
//   bitwise ops to in1/in2. An accumulate packet instead folds its beats into
//   a single result, using the packet's first op and the running value in
//   place of in2. Each result reaches the output register one cycle after
//   the beat that produces it.
//
// Ports
//   clock, reset_n          clock; asynchronous active-low reset
//   in_valid / in_ready     input beat handshake
//   in1, in2, op            operands and op select
//                           (000 AND, 001 OR, 010 XOR, 011 NAND,
//                            100 NOR, 101 XNOR, 110 ANDN, 111 PASS in1)
//   acc_en, in_last         start an accumulate packet / final beat of one
//   out_valid / out_ready   output handshake
//   out, out_zero           result and its zero flag
//   out_beats               number of beats folded into out
//
// FSM states
//   state | meaning
//   IDLE  | between packets; a beat is either a single op or a packet start
//   ACCUM | inside a packet; folding in1 into acc_q with the latched op_q

module bitwise_logic_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_beats
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [2:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;

  logic               accept;
  logic               emit;
  logic [CNT_W-1:0]   emit_beats;
  logic [2:0]         op_sel;
  logic [WIDTH-1:0]   opnd_b;
  logic [WIDTH-1:0]   res;

  function automatic logic [WIDTH-1:0] bit_op(input logic [2:0]       sel,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (sel)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a ^ b;
      3'b011:  r = ~(a & b);
      3'b100:  r = ~(a | b);
      3'b101:  r = ~(a ^ b);
      3'b110:  r = a & ~b;
      default: r = a;
    endcase
    return r;
  endfunction

  // Single output stage without skid buffer: a new beat can only enter when
  // the result register is empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // The counter sticks at its maximum; folding itself is unaffected.
  assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      op_q    <= 3'b000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    emit       = 1'b0;
    emit_beats = CNT_ONE;

    // Inside a packet the op is frozen and the running value replaces in2.
    op_sel = op;
    opnd_b = in2;
    if (state_q == ACCUM) begin
      op_sel = op_q;
      opnd_b = acc_q;
    end
    res = bit_op(op_sel, in1, opnd_b);

    if (accept) begin
      case (state_q)
        IDLE: begin
          if (!acc_en || in_last) begin
            emit = 1'b1;
          end else begin
            acc_d   = res;
            op_d    = op;
            cnt_d   = CNT_ONE;
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (in_last) begin
            emit       = 1'b1;
            emit_beats = cnt_inc;
            acc_d      = '0;
            state_d    = IDLE;
          end else begin
            acc_d = res;
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A new result always wins over a drain in the same cycle, so out_valid
  // stays high when out_ready coincides with an emitting beat.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_zero  <= 1'b1;
      out_beats <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out       <= res;
      out_zero  <= (res == '0);
      out_beats <= emit_beats;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Testbench for bitwise_logic_pipe (WIDTH=32, CNT_W=8).
// A negedge monitor keeps a packet-level reference model and checks every
// cycle; directed sections check literal results for the corner cases.

module tb_bitwise_logic_pipe;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic [2:0]  op = 3'b000;
  logic        acc_en = 1'b0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out;
  logic        out_zero;
  logic [7:0]  out_beats;

  int checks = 0;
  int errors = 0;

  bitwise_logic_pipe #(.WIDTH(32), .CNT_W(8)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in1      (in1),
    .in2      (in2),
    .op       (op),
    .acc_en   (acc_en),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .out_zero (out_zero),
    .out_beats(out_beats)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return a & ~b;
      default: return a;
    endcase
  endfunction

  // Reference model: one pending result slot plus the open packet (if any).
  logic        m_valid = 1'b0;
  logic [31:0] m_out = '0;
  int          m_beats = 0;
  logic        m_inpkt = 1'b0;
  logic [31:0] m_acc = '0;
  logic [2:0]  m_op = 3'b000;
  int          m_n = 0;

  always @(negedge clock) begin
    logic        take;
    logic        fire;
    logic [31:0] r;
    int          nb;
    if (!reset_n) begin
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_zero", out_zero, 1'b1);
      chk("rst_out_beats", out_beats, 8'd0);
      m_valid = 1'b0;
      m_out   = '0;
      m_beats = 0;
      m_inpkt = 1'b0;
      m_acc   = '0;
      m_n     = 0;
    end else begin
      chk("mon_out_valid", out_valid, m_valid);
      chk("mon_in_ready", in_ready, !m_valid || out_ready);
      if (m_valid) begin
        chk("mon_out", out, m_out);
        chk("mon_out_zero", out_zero, m_out == 32'd0);
        chk("mon_out_beats", out_beats, m_beats[7:0]);
      end
      take = in_valid && (!m_valid || out_ready);
      fire = 1'b0;
      r    = '0;
      nb   = 1;
      if (take) begin
        if (!m_inpkt) begin
          r = ref_op(op, in1, in2);
          if (!acc_en || in_last) begin
            fire = 1'b1;
          end else begin
            m_inpkt = 1'b1;
            m_acc   = r;
            m_op    = op;
            m_n     = 1;
          end
        end else begin
          r   = ref_op(m_op, in1, m_acc);
          m_n = m_n + 1;
          if (in_last) begin
            fire    = 1'b1;
            nb      = (m_n > 255) ? 255 : m_n;
            m_inpkt = 1'b0;
            m_acc   = '0;
          end else begin
            m_acc = r;
          end
        end
      end
      if (fire) begin
        m_valid = 1'b1;
        m_out   = r;
        m_beats = nb;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        zero;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic ae, input logic il);
    in_valid = v;
    op       = o;
    in1      = a;
    in2      = b;
    acc_en   = ae;
    in_last  = il;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    vecs[0] = '{3'd0, 32'hF0F0_00FF, 32'hFF00_0F0F, 32'hF000_000F, 1'b0};
    vecs[1] = '{3'd1, 32'hF0F0_00FF, 32'hFF00_0F0F, 32'hFFF0_0FFF, 1'b0};
    vecs[2] = '{3'd2, 32'hF0F0_00FF, 32'hFF00_0F0F, 32'h0FF0_0FF0, 1'b0};
    vecs[3] = '{3'd3, 32'hF0F0_00FF, 32'hFF00_0F0F, 32'h0FFF_FFF0, 1'b0};
    vecs[4] = '{3'd4, 32'hF0F0_00FF, 32'hFF00_0F0F, 32'h000F_F000, 1'b0};
    vecs[5] = '{3'd5, 32'hF0F0_00FF, 32'hFF00_0F0F, 32'hF00F_F00F, 1'b0};
    vecs[6] = '{3'd6, 32'hF0F0_00FF, 32'hFF00_0F0F, 32'h00F0_00F0, 1'b0};
    vecs[7] = '{3'd7, 32'hF0F0_00FF, 32'hFF00_0F0F, 32'hF0F0_00FF, 1'b0};
    vecs[8] = '{3'd0, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 1'b1};

    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Single ops and zero flag, 1-cycle latency.
    for (int i = 0; i < 9; i++) begin
      tick();
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b1);
      tick();
      in_valid = 1'b0;
      @(negedge clock);
      chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_out", i), out, vecs[i].exp);
      chk($sformatf("vec%0d_zero", i), out_zero, vecs[i].zero);
      chk($sformatf("vec%0d_beats", i), out_beats, 8'd1);
    end
    drain();

    // Accumulate OR over 4 beats; op/in2 changes after the first beat are ignored.
    drive(1'b1, 3'd1, 32'h1, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 3'd0, 32'h2, 32'hFFFF_FFFF, 1'b0, 1'b0);
    @(negedge clock);
    chk("acc_no_valid0", out_valid, 1'b0);
    tick();
    drive(1'b1, 3'd2, 32'h4, 32'h1234_5678, 1'b1, 1'b0);
    @(negedge clock);
    chk("acc_no_valid1", out_valid, 1'b0);
    tick();
    drive(1'b1, 3'd4, 32'h8, 32'hFFFF_0000, 1'b0, 1'b1);
    @(negedge clock);
    chk("acc_no_valid2", out_valid, 1'b0);
    tick();
    in_valid = 1'b0;
    @(negedge clock);
    chk("acc_valid", out_valid, 1'b1);
    chk("acc_out", out, 32'h0000_000F);
    chk("acc_beats", out_beats, 8'd4);
    drain();

    // Backpressure with continuous in_valid.
    drive(1'b1, 3'd7, 32'h1111_1111, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd7, 32'h2222_2222, 32'h0, 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk($sformatf("bp_in_ready%0d", c), in_ready, 1'b0);
      chk($sformatf("bp_hold%0d", c), out, 32'h1111_1111);
      chk($sformatf("bp_valid%0d", c), out_valid, 1'b1);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clock);
    chk("bp_release_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    @(negedge clock);
    chk("bp_second_valid", out_valid, 1'b1);
    chk("bp_second_out", out, 32'h2222_2222);
    tick();
    @(negedge clock);
    chk("bp_no_dup", out_valid, 1'b0);
    drain();

    // Reset in the middle of a packet.
    drive(1'b1, 3'd1, 32'h0, 32'h1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd1, 32'h3, 32'h5, 1'b1, 1'b0);
    tick();
    drive(1'b1, 3'd1, 32'h4, 32'h0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_zero", out_zero, 1'b1);
    chk("arst_out_beats", out_beats, 8'd0);
    tick();
    reset_n = 1'b1;
    drive(1'b1, 3'd0, 32'h0000_FFFF, 32'h00FF_00FF, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    @(negedge clock);
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_out", out, 32'h0000_00FF);
    chk("post_rst_beats", out_beats, 8'd1);
    drain();

    // Saturation: 300-beat XOR packet.
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, 3'd2, 32'h1, 32'h0, k == 0, k == 299);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clock);
    chk("sat_valid", out_valid, 1'b1);
    chk("sat_out", out, 32'h0);
    chk("sat_zero", out_zero, 1'b1);
    chk("sat_beats", out_beats, 8'd255);
    drain();

    // Random traffic against the monitor model.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = 3'($urandom_range(0, 7));
      in1       = $urandom & $urandom;
      in2       = $urandom | $urandom;
      acc_en    = 1'($urandom_range(0, 1));
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drive(1'b1, 3'd7, 32'h0, 32'h0, 1'b0, 1'b1);
    out_ready = 1'b1;
    tick();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
